// File: rtl/ctrl_sequencer.sv
// Hardwired control sequencer for a multi-cycle datapath: fetch, per-class execute
// sequences, memory wait with optional timeout, HALT and sticky FAULT states.
module ctrl_sequencer #(
    parameter int IR_W        = 32,
    parameter int OPC_W       = 5,
    parameter int MD_LAT      = 1,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic            Clock,
    input  logic            Reset_n,
    input  logic [IR_W-1:0] IR,
    input  logic            CON_out,
    input  logic            MemReady,
    input  logic            Stop,
    input  logic            Resume,
    output logic            PCout, MARin, IncPC, PCin, Read, Write, MDRin, MDRout,
    output logic            IRin, Gra, Grb, Grc, Rin, Rout, BAout, Cout,
    output logic            Yin, ZLowIn, ZHighIn, ZLowout, ZHighout, LOin, HIin, CON_in,
    output logic            Run,
    output logic            Fault,
    output logic [4:0]      operation
);
    localparam int MDW     = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;
    localparam int WCW     = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam int TO_LAST = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;

    localparam logic [23:0] S_PCOUT = 24'h800000, S_MARIN = 24'h400000, S_INCPC = 24'h200000;
    localparam logic [23:0] S_PCIN = 24'h100000, S_READ = 24'h080000, S_WRITE = 24'h040000;
    localparam logic [23:0] S_MDRIN = 24'h020000, S_MDROUT = 24'h010000, S_IRIN = 24'h008000;
    localparam logic [23:0] S_GRA = 24'h004000, S_GRB = 24'h002000, S_GRC = 24'h001000;
    localparam logic [23:0] S_RIN = 24'h000800, S_ROUT = 24'h000400, S_BAOUT = 24'h000200;
    localparam logic [23:0] S_COUT = 24'h000100, S_YIN = 24'h000080, S_ZLOWIN = 24'h000040;
    localparam logic [23:0] S_ZHIGHIN = 24'h000020, S_ZLOWOUT = 24'h000010, S_ZHIGHOUT = 24'h000008;
    localparam logic [23:0] S_LOIN = 24'h000004, S_HIIN = 24'h000002, S_CONIN = 24'h000001;

    typedef enum logic [4:0] {
        ST_RST, ST_F0, ST_F1, ST_F2, ST_A3, ST_A4, ST_A5, ST_I3, ST_I4, ST_I5,
        ST_M3, ST_M4, ST_M5, ST_M6, ST_L3, ST_L4, ST_L5, ST_L6, ST_L7,
        ST_S3, ST_S4, ST_S5, ST_S6, ST_S7, ST_B3, ST_B4, ST_B5, ST_B6,
        ST_NOP, ST_HALT, ST_FAULT
    } state_t;

    state_t           r_state, w_next;
    logic [4:0]       r_opc, r_op, w_opc;
    logic [MDW-1:0]   r_mdcnt;
    logic [WCW-1:0]   r_wcnt;
    logic             r_stop_pend, r_run, r_fault;
    logic [23:0]      r_strb;
    logic             w_stop, w_timeout, w_in_mem, w_unused_ir;

    assign w_opc       = 5'(IR[IR_W-1 -: OPC_W]);
    assign w_unused_ir = ^IR[IR_W-OPC_W-1:0];
    assign w_stop      = r_stop_pend | Stop;
    assign w_in_mem    = (r_state == ST_F1) || (r_state == ST_L6) || (r_state == ST_S7);
    assign w_timeout   = (MEM_TIMEOUT > 0) && (r_wcnt == WCW'(TO_LAST));

    function automatic logic [23:0] strb_of(input state_t s, input logic con);
        case (s)
            ST_F0:   return S_PCOUT | S_MARIN | S_INCPC | S_PCIN;
            ST_F1:   return S_READ | S_MDRIN;
            ST_F2:   return S_MDROUT | S_IRIN;
            ST_A3, ST_I3, ST_M3: return ((s == ST_M3) ? S_GRA : S_GRB) | S_ROUT | S_YIN;
            ST_A4:   return S_GRC | S_ROUT | S_ZLOWIN;
            ST_A5, ST_I5, ST_L7: return ((s == ST_L7) ? S_MDROUT : S_ZLOWOUT) | S_GRA | S_RIN;
            ST_I4, ST_L4, ST_S4, ST_B5: return S_COUT | S_ZLOWIN;
            ST_M4:   return S_GRB | S_ROUT | S_ZLOWIN | S_ZHIGHIN;
            ST_M5:   return S_ZLOWOUT | S_LOIN;
            ST_M6:   return S_ZHIGHOUT | S_HIIN;
            ST_L3, ST_S3: return S_GRB | S_BAOUT | S_YIN;
            ST_L5, ST_S5: return S_ZLOWOUT | S_MARIN;
            ST_L6:   return S_READ | S_MDRIN;
            ST_S6:   return S_GRA | S_ROUT | S_MDRIN;
            ST_S7:   return S_MDROUT | S_WRITE;
            ST_B3:   return S_GRA | S_ROUT | S_CONIN;
            ST_B4:   return S_PCOUT | S_YIN;
            ST_B6:   return con ? (S_ZLOWOUT | S_PCIN) : 24'h000000;
            default: return 24'h000000;
        endcase
    endfunction

    function automatic logic [4:0] op_of(input state_t s, input logic [4:0] opc);
        case (s)
            ST_A4, ST_M4: return opc;
            ST_L4, ST_S4, ST_B5: return 5'b00011;
            ST_I4: begin
                case (opc)
                    5'b01100: return 5'b00011;
                    5'b01101: return 5'b00101;
                    5'b01110: return 5'b00110;
                    default:  return 5'b00000;
                endcase
            end
            default: return 5'b00000;
        endcase
    endfunction

    // Next-state decode; a pending stop diverts the instruction boundary into HALT
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_RST: w_next = ST_F0;
            ST_F0:  w_next = ST_F1;
            ST_F1:  w_next = MemReady ? ST_F2 : (w_timeout ? ST_FAULT : ST_F1);
            ST_F2: begin
                case (w_opc)
                    5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
                    5'b01000, 5'b01001, 5'b01010, 5'b01011: w_next = ST_A3;
                    5'b01100, 5'b01101, 5'b01110: w_next = ST_I3;
                    5'b01111, 5'b10000: w_next = ST_M3;
                    5'b00000: w_next = ST_L3;
                    5'b00010: w_next = ST_S3;
                    5'b10011: w_next = ST_B3;
                    5'b11010: w_next = ST_NOP;
                    5'b11011: w_next = ST_HALT;
                    default:  w_next = ST_FAULT;
                endcase
            end
            ST_A3: w_next = ST_A4;
            ST_A4: w_next = ST_A5;
            ST_I3: w_next = ST_I4;
            ST_I4: w_next = ST_I5;
            ST_M3: w_next = ST_M4;
            ST_M4: w_next = (r_mdcnt == {MDW{1'b0}}) ? ST_M5 : ST_M4;
            ST_M5: w_next = ST_M6;
            ST_L3: w_next = ST_L4;
            ST_L4: w_next = ST_L5;
            ST_L5: w_next = ST_L6;
            ST_L6: w_next = MemReady ? ST_L7 : (w_timeout ? ST_FAULT : ST_L6);
            ST_S3: w_next = ST_S4;
            ST_S4: w_next = ST_S5;
            ST_S5: w_next = ST_S6;
            ST_S6: w_next = ST_S7;
            ST_S7: begin
                if (MemReady) w_next = w_stop ? ST_HALT : ST_F0;
                else          w_next = w_timeout ? ST_FAULT : ST_S7;
            end
            ST_B3: w_next = ST_B4;
            ST_B4: w_next = ST_B5;
            ST_B5: w_next = ST_B6;
            ST_A5, ST_I5, ST_M6, ST_L7, ST_B6, ST_NOP: w_next = w_stop ? ST_HALT : ST_F0;
            ST_HALT:  w_next = Resume ? ST_F0 : ST_HALT;
            ST_FAULT: w_next = ST_FAULT;
            default:  w_next = ST_FAULT;
        endcase
    end

    // State, counters and outputs all register together so outputs track the state exactly
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state     <= ST_RST;
            r_opc       <= 5'd0;
            r_mdcnt     <= {MDW{1'b0}};
            r_wcnt      <= {WCW{1'b0}};
            r_stop_pend <= 1'b0;
            r_strb      <= 24'd0;
            r_op        <= 5'd0;
            r_run       <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_state <= w_next;
            r_strb  <= strb_of(w_next, CON_out);
            r_op    <= op_of(w_next, r_opc);
            r_run   <= (w_next != ST_RST) && (w_next != ST_HALT) && (w_next != ST_FAULT);
            r_fault <= (w_next == ST_FAULT);
            if (r_state == ST_F2) r_opc <= w_opc;
            else                  r_opc <= r_opc;
            if ((w_next == ST_M4) && (r_state != ST_M4)) r_mdcnt <= MDW'(MD_LAT - 1);
            else if (r_state == ST_M4)                   r_mdcnt <= r_mdcnt - MDW'(1);
            else                                         r_mdcnt <= r_mdcnt;
            if (w_in_mem && (w_next == r_state)) r_wcnt <= r_wcnt + WCW'(1);
            else                                 r_wcnt <= {WCW{1'b0}};
            // A stop request raised mid-instruction is remembered until the boundary
            if (w_next == ST_HALT)         r_stop_pend <= 1'b0;
            else if (r_state != ST_HALT)   r_stop_pend <= r_stop_pend | Stop;
            else                           r_stop_pend <= r_stop_pend;
        end
    end

    assign {PCout, MARin, IncPC, PCin, Read, Write, MDRin, MDRout, IRin, Gra, Grb, Grc,
            Rin, Rout, BAout, Cout, Yin, ZLowIn, ZHighIn, ZLowout, ZHighout, LOin, HIin,
            CON_in} = r_strb;
    assign operation = r_op;
    assign Run       = r_run;
    assign Fault     = r_fault;
endmodule

// File: tb/tb_ctrl_sequencer.sv
// Scoreboard bench for ctrl_sequencer: per-cycle expected strobes queued with their stimulus.
module tb_ctrl_sequencer;
    localparam logic [23:0] PCOUT = 24'h800000, MARIN = 24'h400000, INCPC = 24'h200000;
    localparam logic [23:0] PCIN = 24'h100000, READ = 24'h080000, WRITE = 24'h040000;
    localparam logic [23:0] MDRIN = 24'h020000, MDROUT = 24'h010000, IRIN = 24'h008000;
    localparam logic [23:0] GRA = 24'h004000, GRB = 24'h002000, GRC = 24'h001000;
    localparam logic [23:0] RIN = 24'h000800, ROUT = 24'h000400, BAOUT = 24'h000200;
    localparam logic [23:0] COUT = 24'h000100, YIN = 24'h000080, ZLOWIN = 24'h000040;
    localparam logic [23:0] ZHIGHIN = 24'h000020, ZLOWOUT = 24'h000010, ZHIGHOUT = 24'h000008;
    localparam logic [23:0] LOIN = 24'h000004, HIIN = 24'h000002, CONIN = 24'h000001;
    localparam int TB_MD_LAT = 4;

    logic        Clock = 1'b0, Reset_n = 1'b1;
    logic [31:0] IR = 32'd0;
    logic        CON_out = 1'b0, MemReady = 1'b1, Stop = 1'b0, Resume = 1'b0;
    logic [23:0] sm, st;
    logic [4:0]  opm, opt;
    logic        runm, fltm, runt, fltt;
    logic [30:0] obs_m, obs_t;
    int          n_chk = 0, n_fail = 0;

    assign obs_m = {sm, opm, runm, fltm};
    assign obs_t = {st, opt, runt, fltt};

    always #5 Clock = ~Clock;

    ctrl_sequencer #(.IR_W(32), .OPC_W(5), .MD_LAT(TB_MD_LAT), .MEM_TIMEOUT(16)) dut (
        .Clock(Clock), .Reset_n(Reset_n), .IR(IR), .CON_out(CON_out), .MemReady(MemReady),
        .Stop(Stop), .Resume(Resume),
        .PCout(sm[23]), .MARin(sm[22]), .IncPC(sm[21]), .PCin(sm[20]), .Read(sm[19]),
        .Write(sm[18]), .MDRin(sm[17]), .MDRout(sm[16]), .IRin(sm[15]), .Gra(sm[14]),
        .Grb(sm[13]), .Grc(sm[12]), .Rin(sm[11]), .Rout(sm[10]), .BAout(sm[9]), .Cout(sm[8]),
        .Yin(sm[7]), .ZLowIn(sm[6]), .ZHighIn(sm[5]), .ZLowout(sm[4]), .ZHighout(sm[3]),
        .LOin(sm[2]), .HIin(sm[1]), .CON_in(sm[0]),
        .Run(runm), .Fault(fltm), .operation(opm));

    ctrl_sequencer #(.IR_W(32), .OPC_W(5), .MD_LAT(1), .MEM_TIMEOUT(2)) dut_to (
        .Clock(Clock), .Reset_n(Reset_n), .IR(IR), .CON_out(CON_out), .MemReady(MemReady),
        .Stop(Stop), .Resume(Resume),
        .PCout(st[23]), .MARin(st[22]), .IncPC(st[21]), .PCin(st[20]), .Read(st[19]),
        .Write(st[18]), .MDRin(st[17]), .MDRout(st[16]), .IRin(st[15]), .Gra(st[14]),
        .Grb(st[13]), .Grc(st[12]), .Rin(st[11]), .Rout(st[10]), .BAout(st[9]), .Cout(st[8]),
        .Yin(st[7]), .ZLowIn(st[6]), .ZHighIn(st[5]), .ZLowout(st[4]), .ZHighout(st[3]),
        .LOin(st[2]), .HIin(st[1]), .CON_in(st[0]),
        .Run(runt), .Fault(fltt), .operation(opt));

    // One entry per clock: inputs applied before the edge and the outputs expected after it
    typedef struct {
        string       nm;
        logic [30:0] exp;
        logic [31:0] ir;
        logic        mr, con, stp, rsm;
    } ent_t;
    ent_t        sbq[$];
    logic [31:0] sc_ir  = 32'd0;
    logic        sc_con = 1'b0;

    function automatic void push(input string nm, input logic [23:0] s, input logic [4:0] op = 5'd0,
                                 input logic run = 1'b1, input logic flt = 1'b0, input logic mr = 1'b1,
                                 input logic stp = 1'b0, input logic rsm = 1'b0);
        ent_t e;
        e.nm = nm; e.exp = {s, op, run, flt}; e.ir = sc_ir; e.con = sc_con;
        e.mr = mr; e.stp = stp; e.rsm = rsm;
        sbq.push_back(e);
    endfunction

    function automatic logic [31:0] mk_ir(input logic [4:0] opc);
        logic [31:0] v;
        v = {opc, 27'h0A5B3C1};
        return v;
    endfunction

    function automatic void exp_fetch();
        push("F0", PCOUT | MARIN | INCPC | PCIN);
        push("F1", READ | MDRIN);
        push("F2", MDROUT | IRIN);
    endfunction

    task automatic drive(input ent_t e);
        MemReady = e.mr; IR = e.ir; CON_out = e.con; Stop = e.stp; Resume = e.rsm;
        @(posedge Clock);
        #1;
    endtask

    task automatic do_reset();
        Reset_n = 1'b0; MemReady = 1'b1; Stop = 1'b0; Resume = 1'b0; CON_out = 1'b0;
        @(negedge Clock);
        @(negedge Clock);
        Reset_n = 1'b1;
    endtask

    task automatic test_reset();
        ent_t e;
        #1 Reset_n = 1'b0;
        #1;
        n_chk++; if (obs_m !== 31'd0) begin n_fail++; $display("FAIL reset_main: got %h expected %h", obs_m, 31'd0); end
        n_chk++; if (obs_t !== 31'd0) begin n_fail++; $display("FAIL reset_to: got %h expected %h", obs_t, 31'd0); end
        @(posedge Clock); #1;
        n_chk++; if (obs_m !== 31'd0) begin n_fail++; $display("FAIL reset_held: got %h expected %h", obs_m, 31'd0); end
        @(negedge Clock) Reset_n = 1'b1;
        push("F0", PCOUT | MARIN | INCPC | PCIN);
        while (sbq.size() > 0) begin
            e = sbq.pop_front(); drive(e); n_chk++;
            if (obs_m !== e.exp) begin n_fail++; $display("FAIL reset/%s: got %h expected %h", e.nm, obs_m, e.exp); end
        end
    endtask

    task automatic test_alu();
        ent_t e;
        do_reset();
        sc_ir = mk_ir(5'b00011);
        exp_fetch();
        push("A3", GRB | ROUT | YIN);
        push("A4", GRC | ROUT | ZLOWIN, 5'b00011);
        push("A5", ZLOWOUT | GRA | RIN);
        sc_ir = mk_ir(5'b01011);
        exp_fetch();
        push("A3", GRB | ROUT | YIN);
        push("A4", GRC | ROUT | ZLOWIN, 5'b01011);
        push("A5", ZLOWOUT | GRA | RIN);
        push("F0", PCOUT | MARIN | INCPC | PCIN);
        while (sbq.size() > 0) begin
            e = sbq.pop_front(); drive(e); n_chk++;
            if (obs_m !== e.exp) begin n_fail++; $display("FAIL alu/%s: got %h expected %h", e.nm, obs_m, e.exp); end
        end
    endtask

    task automatic test_imm();
        ent_t e;
        do_reset();
        sc_ir = mk_ir(5'b01101);
        exp_fetch();
        push("I3", GRB | ROUT | YIN);
        push("I4", COUT | ZLOWIN, 5'b00101);
        push("I5", ZLOWOUT | GRA | RIN);
        sc_ir = mk_ir(5'b01110);
        exp_fetch();
        push("I3", GRB | ROUT | YIN);
        push("I4", COUT | ZLOWIN, 5'b00110);
        push("I5", ZLOWOUT | GRA | RIN);
        push("F0", PCOUT | MARIN | INCPC | PCIN);
        while (sbq.size() > 0) begin
            e = sbq.pop_front(); drive(e); n_chk++;
            if (obs_m !== e.exp) begin n_fail++; $display("FAIL imm/%s: got %h expected %h", e.nm, obs_m, e.exp); end
        end
    endtask

    task automatic test_md();
        ent_t e;
        do_reset();
        sc_ir = mk_ir(5'b10000);
        exp_fetch();
        push("M3", GRA | ROUT | YIN);
        for (int i = 0; i < TB_MD_LAT; i++) push("M4", GRB | ROUT | ZLOWIN | ZHIGHIN, 5'b10000);
        push("M5", ZLOWOUT | LOIN);
        push("M6", ZHIGHOUT | HIIN);
        push("F0", PCOUT | MARIN | INCPC | PCIN);
        while (sbq.size() > 0) begin
            e = sbq.pop_front(); drive(e); n_chk++;
            if (obs_m !== e.exp) begin n_fail++; $display("FAIL md/%s: got %h expected %h", e.nm, obs_m, e.exp); end
        end
    endtask

    task automatic test_ld_wait();
        ent_t e;
        do_reset();
        sc_ir = mk_ir(5'b00000);
        exp_fetch();
        push("L3", GRB | BAOUT | YIN);
        push("L4", COUT | ZLOWIN, 5'b00011);
        push("L5", ZLOWOUT | MARIN);
        push("L6", READ | MDRIN);
        for (int i = 0; i < 3; i++) push("L6w", READ | MDRIN, 5'd0, 1'b1, 1'b0, 1'b0);
        push("L7", MDROUT | GRA | RIN);
        push("F0", PCOUT | MARIN | INCPC | PCIN);
        while (sbq.size() > 0) begin
            e = sbq.pop_front(); drive(e); n_chk++;
            if (obs_m !== e.exp) begin n_fail++; $display("FAIL ld/%s: got %h expected %h", e.nm, obs_m, e.exp); end
        end
        n_chk++;
        if (obs_t !== {24'd0, 5'd0, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL ld_timeout: got %h expected %h", obs_t, {24'd0, 5'd0, 1'b0, 1'b1});
        end
    endtask

    task automatic test_br();
        ent_t e;
        do_reset();
        sc_ir = mk_ir(5'b10011);
        for (int c = 0; c < 2; c++) begin
            sc_con = (c == 1);
            exp_fetch();
            push("B3", GRA | ROUT | CONIN);
            push("B4", PCOUT | YIN);
            push("B5", COUT | ZLOWIN, 5'b00011);
            push("B6", (c == 1) ? (ZLOWOUT | PCIN) : 24'd0);
        end
        push("F0", PCOUT | MARIN | INCPC | PCIN);
        while (sbq.size() > 0) begin
            e = sbq.pop_front(); drive(e); n_chk++;
            if (obs_m !== e.exp) begin n_fail++; $display("FAIL br/%s con=%0b: got %h expected %h", e.nm, e.con, obs_m, e.exp); end
        end
        sc_con = 1'b0;
    endtask

    task automatic test_halt_fault();
        ent_t e;
        do_reset();
        sc_ir = mk_ir(5'b00011);
        exp_fetch();
        push("A3", GRB | ROUT | YIN);
        push("A4", GRC | ROUT | ZLOWIN, 5'b00011);
        push("A5", ZLOWOUT | GRA | RIN, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);
        push("HALT", 24'd0, 5'd0, 1'b0);
        push("HALT2", 24'd0, 5'd0, 1'b0);
        push("F0res", PCOUT | MARIN | INCPC | PCIN, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        sc_ir = mk_ir(5'b11011);
        push("F1", READ | MDRIN);
        push("F2", MDROUT | IRIN);
        push("HALTop", 24'd0, 5'd0, 1'b0);
        push("F0both", PCOUT | MARIN | INCPC | PCIN, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        sc_ir = mk_ir(5'b11111);
        push("F1", READ | MDRIN);
        push("F2", MDROUT | IRIN);
        push("FAULT", 24'd0, 5'd0, 1'b0, 1'b1);
        push("FAULT2", 24'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        push("FAULT3", 24'd0, 5'd0, 1'b0, 1'b1);
        while (sbq.size() > 0) begin
            e = sbq.pop_front(); drive(e); n_chk++;
            if (obs_m !== e.exp) begin n_fail++; $display("FAIL halt/%s: got %h expected %h", e.nm, obs_m, e.exp); end
        end
        Reset_n = 1'b0;
        #1;
        n_chk++; if (obs_m !== 31'd0) begin n_fail++; $display("FAIL fault_reset: got %h expected %h", obs_m, 31'd0); end
    endtask

    task automatic test_st_reset();
        ent_t e;
        do_reset();
        sc_ir = mk_ir(5'b00010);
        exp_fetch();
        push("S3", GRB | BAOUT | YIN);
        push("S4", COUT | ZLOWIN, 5'b00011);
        push("S5", ZLOWOUT | MARIN);
        push("S6", GRA | ROUT | MDRIN);
        push("S7", MDROUT | WRITE);
        push("S7w", MDROUT | WRITE, 5'd0, 1'b1, 1'b0, 1'b0);
        while (sbq.size() > 0) begin
            e = sbq.pop_front(); drive(e); n_chk++;
            if (obs_m !== e.exp) begin n_fail++; $display("FAIL st/%s: got %h expected %h", e.nm, obs_m, e.exp); end
        end
        #2 Reset_n = 1'b0;
        #1;
        n_chk++; if (sm[18] !== 1'b0 || obs_m !== 31'd0) begin n_fail++; $display("FAIL st_async_reset: got %h expected %h", obs_m, 31'd0); end
        @(negedge Clock) Reset_n = 1'b1;
        push("F0", PCOUT | MARIN | INCPC | PCIN);
        while (sbq.size() > 0) begin
            e = sbq.pop_front(); drive(e); n_chk++;
            if (obs_m !== e.exp) begin n_fail++; $display("FAIL st_restart/%s: got %h expected %h", e.nm, obs_m, e.exp); end
        end
    endtask

    task automatic test_back_to_back();
        ent_t e;
        do_reset();
        sc_ir = mk_ir(5'b11010);
        exp_fetch();
        push("NOP", 24'd0);
        sc_ir = mk_ir(5'b00010);
        exp_fetch();
        push("S3", GRB | BAOUT | YIN);
        push("S4", COUT | ZLOWIN, 5'b00011);
        push("S5", ZLOWOUT | MARIN);
        push("S6", GRA | ROUT | MDRIN);
        push("S7", MDROUT | WRITE);
        push("F0", PCOUT | MARIN | INCPC | PCIN);
        while (sbq.size() > 0) begin
            e = sbq.pop_front(); drive(e); n_chk++;
            if (obs_m !== e.exp) begin n_fail++; $display("FAIL b2b/%s: got %h expected %h", e.nm, obs_m, e.exp); end
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_imm();
        test_md();
        test_ld_wait();
        test_br();
        test_halt_fault();
        test_st_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
